// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the MEM pipeline stage and its ack watchdog.
package mem_stage_pkg;

   typedef enum logic {
      MEM_IDLE   = 1'b0,
      MEM_ACCESS = 1'b1
   } mem_state_e;

   localparam int DATA_W_DEF     = 16;
   localparam int ADDR_W_DEF     = 16;
   localparam int REG_ADDR_W_DEF = 4;
   localparam int MAX_WAIT_DEF   = 15;

   // Watchdog counts 0..MAX_WAIT-1, so it never needs to hold MAX_WAIT itself.
   function automatic int cnt_width(input int max_wait);
      return (max_wait < 2) ? 1 : $clog2(max_wait);
   endfunction

endpackage

// File: rtl/mem_stage_wdog.sv
// Ack watchdog: counts ACCESS cycles without ack; o_expired is combinational in the last allowed cycle.
// Only instantiated when MEM_TIMEOUT_EN is defined; no backpressure of its own.
module mem_stage_wdog
   import mem_stage_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int            CW    = cnt_width(MAX_WAIT);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

   logic [CW-1:0] r_cnt;
   logic          w_expired;

   assign w_expired = i_en & (r_cnt == LIMIT);
   assign o_expired = w_expired;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_expired) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: non-memory ops pass in 1 cycle, loads/stores take 2+ cycles over a req/ack port while stallReq_o holds upstream.
// Optional ack timeout via MEM_TIMEOUT_EN (gives up after MAX_WAIT cycles and pulses memErr_o).
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic                  flush_i,
   input  logic                  memRead_i,
   input  logic                  memWrite_i,
   input  logic [ADDR_W-1:0]     memAddr_i,
   input  logic [DATA_W-1:0]     memData_i,
   input  logic [DATA_W-1:0]     wData_i,
   input  logic                  wReg_i,
   input  logic [REG_ADDR_W-1:0] wRegAddr_i,
   output logic                  stallReq_o,
   output logic                  memReq_o,
   output logic                  memWe_o,
   output logic [ADDR_W-1:0]     memAddr_o,
   output logic [DATA_W-1:0]     memWdata_o,
   input  logic                  memAck_i,
   input  logic [DATA_W-1:0]     memRdata_i,
   output logic                  valid_o,
   output logic [DATA_W-1:0]     wData_o,
   output logic                  wReg_o,
   output logic [REG_ADDR_W-1:0] wRegAddr_o,
   output logic                  memErr_o
);

   if (MAX_WAIT < 1) begin : g_bad_max_wait
      $error("mem_stage: MAX_WAIT must be at least 1");
   end

   mem_state_e r_state;
   mem_state_e w_state_nxt;

   logic                  w_memop;
   logic                  w_expired;
   logic                  w_stall;
   logic                  w_kill;

   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_alu;
   logic                  r_is_load;
   logic                  r_kill;
   logic                  r_wreg_lat;
   logic [REG_ADDR_W-1:0] r_wreg_addr_lat;

   logic                  r_valid;
   logic [DATA_W-1:0]     r_wdata_o;
   logic                  r_wreg;
   logic [REG_ADDR_W-1:0] r_wreg_addr_o;

   assign w_memop = valid_i & (memRead_i | memWrite_i);
   // A flush arriving in the ack cycle still squashes the writeback.
   assign w_kill  = r_kill | flush_i;

`ifdef MEM_TIMEOUT_EN
   logic w_wdog_clr;
   logic w_wdog_en;
   logic r_mem_err;

   assign w_wdog_clr = (r_state == MEM_IDLE) & w_memop;
   assign w_wdog_en  = (r_state == MEM_ACCESS) & ~memAck_i;

   mem_stage_wdog #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_wdog_clr),
      .i_en      (w_wdog_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_err <= 1'b0;
      end else begin
         r_mem_err <= w_expired;
      end
   end

   assign memErr_o = r_mem_err;
`else
   assign w_expired = 1'b0;
   assign memErr_o  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MEM_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MEM_IDLE:   if (w_memop) w_state_nxt = MEM_ACCESS;
         MEM_ACCESS: if (memAck_i || w_expired) w_state_nxt = MEM_IDLE;
         default:    w_state_nxt = MEM_IDLE;
      endcase
   end

   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         MEM_IDLE:   w_stall = w_memop;
         MEM_ACCESS: w_stall = ~memAck_i & ~w_expired;
         default:    w_stall = 1'b0;
      endcase
   end

   assign stallReq_o = w_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_req       <= 1'b0;
         r_mem_we        <= 1'b0;
         r_addr          <= '0;
         r_wdata         <= '0;
         r_alu           <= '0;
         r_is_load       <= 1'b0;
         r_kill          <= 1'b0;
         r_wreg_lat      <= 1'b0;
         r_wreg_addr_lat <= '0;
         r_valid         <= 1'b0;
         r_wdata_o       <= '0;
         r_wreg          <= 1'b0;
         r_wreg_addr_o   <= '0;
      end else begin
         case (r_state)
            MEM_IDLE: begin
               if (w_memop) begin
                  r_mem_req       <= 1'b1;
                  r_mem_we        <= memWrite_i;
                  r_addr          <= memAddr_i;
                  r_wdata         <= memData_i;
                  r_alu           <= wData_i;
                  r_is_load       <= ~memWrite_i;
                  r_kill          <= flush_i;
                  r_wreg_lat      <= wReg_i;
                  r_wreg_addr_lat <= wRegAddr_i;
                  r_valid         <= 1'b0;
                  r_wreg          <= 1'b0;
               end else begin
                  r_valid         <= valid_i & ~flush_i;
                  r_wdata_o       <= wData_i;
                  r_wreg          <= wReg_i & valid_i & ~flush_i;
                  r_wreg_addr_o   <= wRegAddr_i;
               end
            end
            MEM_ACCESS: begin
               if (memAck_i) begin
                  r_mem_req       <= 1'b0;
                  r_mem_we        <= 1'b0;
                  r_valid         <= ~w_kill;
                  r_wdata_o       <= r_is_load ? memRdata_i : r_alu;
                  r_wreg          <= r_wreg_lat & ~w_kill;
                  r_wreg_addr_o   <= r_wreg_addr_lat;
               end else if (w_expired) begin
                  // Abandoned access still retires a slot, but never writes the register file.
                  r_mem_req       <= 1'b0;
                  r_mem_we        <= 1'b0;
                  r_valid         <= 1'b1;
                  r_wdata_o       <= r_alu;
                  r_wreg          <= 1'b0;
                  r_wreg_addr_o   <= r_wreg_addr_lat;
               end else begin
                  r_kill          <= w_kill;
                  r_valid         <= 1'b0;
                  r_wreg          <= 1'b0;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_valid   <= 1'b0;
               r_wreg    <= 1'b0;
            end
         endcase
      end
   end

   assign memReq_o   = r_mem_req;
   assign memWe_o    = r_mem_we;
   assign memAddr_o  = r_addr;
   assign memWdata_o = r_wdata;
   assign valid_o    = r_valid;
   assign wData_o    = r_wdata_o;
   assign wReg_o     = r_wreg;
   assign wRegAddr_o = r_wreg_addr_o;

endmodule
